// File: rtl/cordic_sincos_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cordic_sincos_hs                                              |
// | Purpose  : Iterative full-circle CORDIC sine/cosine with valid/ready     |
// |            handshakes, one shared add/shift datapath.                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cordic_sincos_hs #(
  parameter int DATA_WIDTH = 8,
  parameter int ITERATIONS = 8,
  parameter int GUARD_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] angle,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] cos_val,
  output logic [DATA_WIDTH-1:0] sin_val,
  output logic                  range_err
);

  localparam int  c_XW = DATA_WIDTH + 1 + GUARD_BITS;
  localparam int  c_FX = DATA_WIDTH - 1 + GUARD_BITS;
  localparam int  c_ZW = DATA_WIDTH + GUARD_BITS;
  localparam int  c_FZ = DATA_WIDTH - 3 + GUARD_BITS;
  localparam int  c_IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam real c_PI = 3.14159265358979323846;

  localparam logic signed [DATA_WIDTH-1:0] c_PI_Q =
    DATA_WIDTH'($rtoi(c_PI * (2.0 ** (DATA_WIDTH - 3)) + 0.5));
  localparam logic signed [DATA_WIDTH-1:0] c_NEG_PI_Q = -c_PI_Q;
  localparam logic signed [c_ZW-1:0] c_PI_Z      = c_ZW'($rtoi(c_PI * (2.0 ** c_FZ) + 0.5));
  localparam logic signed [c_ZW-1:0] c_HPI_Z     = c_ZW'($rtoi(c_PI / 2.0 * (2.0 ** c_FZ) + 0.5));
  localparam logic signed [c_ZW-1:0] c_NEG_HPI_Z = -c_HPI_Z;
  localparam logic signed [c_XW-1:0] c_K         = c_XW'($rtoi(0.6072529350 * (2.0 ** c_FX) + 0.5));
  localparam logic signed [c_XW-1:0] c_NEG_K     = -c_K;
  localparam logic signed [c_XW+1:0] c_RND       = (c_XW+2)'(2 ** GUARD_BITS);
  localparam logic signed [c_XW+1:0] c_OMAX      = (c_XW+2)'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [c_XW+1:0] c_OMIN      = (c_XW+2)'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PREROT = 2'd1,
    S_ITER   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                       r_state;
  logic signed [DATA_WIDTH-1:0] r_angle;
  logic signed [c_XW-1:0]       r_x, r_y;
  logic signed [c_ZW-1:0]       r_z;
  logic [c_IW-1:0]              r_iter;

  logic signed [c_ZW-1:0]       w_atan [2**c_IW];
  logic                         w_clamp_hi, w_clamp_lo;
  logic signed [DATA_WIDTH-1:0] w_clamped;
  logic signed [c_ZW-1:0]       w_a_z, w_z0, w_z_nxt;
  logic signed [c_XW-1:0]       w_x0, w_x_sh, w_y_sh, w_x_nxt, w_y_nxt;

  // Arctangent table padded to a power of two so any counter value indexes safely.
  for (genvar g = 0; g < 2**c_IW; g++) begin : g_atan_lut
    localparam logic signed [c_ZW-1:0] c_ATAN = (g < ITERATIONS) ?
      c_ZW'($rtoi($atan(1.0 / (2.0 ** g)) * (2.0 ** c_FZ) + 0.5)) : '0;
    assign w_atan[g] = c_ATAN;
  end

  // Round half-up from (x + 1/2 LSB) / LSB, computed on 2x so GUARD_BITS=0 also works.
  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [c_XW-1:0] v);
    logic signed [c_XW+1:0] t;
    t = ($signed({v[c_XW-1], v, 1'b0}) + c_RND) >>> (GUARD_BITS + 1);
    if (t > c_OMAX)      t = c_OMAX;
    else if (t < c_OMIN) t = c_OMIN;
    return t[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    w_clamp_hi = r_angle > c_PI_Q;
    w_clamp_lo = r_angle < c_NEG_PI_Q;
    w_clamped  = w_clamp_hi ? c_PI_Q : (w_clamp_lo ? c_NEG_PI_Q : r_angle);
    w_a_z      = c_ZW'(w_clamped) <<< GUARD_BITS;
    w_z0       = w_a_z;
    w_x0       = c_K;
    if (w_a_z > c_HPI_Z) begin
      w_z0 = w_a_z - c_PI_Z;
      w_x0 = c_NEG_K;
    end else if (w_a_z < c_NEG_HPI_Z) begin
      w_z0 = w_a_z + c_PI_Z;
      w_x0 = c_NEG_K;
    end
  end

  always_comb begin
    w_x_sh = r_x >>> r_iter;
    w_y_sh = r_y >>> r_iter;
    if (!r_z[c_ZW-1]) begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan[r_iter];
    end else begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan[r_iter];
    end
  end

  assign in_ready = ~rst & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_angle   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_iter    <= '0;
      out_valid <= 1'b0;
      cos_val   <= '0;
      sin_val   <= '0;
      range_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_angle <= $signed(angle);
            r_state <= S_PREROT;
          end
        end
        S_PREROT: begin
          r_x       <= w_x0;
          r_y       <= '0;
          r_z       <= w_z0;
          r_iter    <= '0;
          range_err <= w_clamp_hi | w_clamp_lo;
          r_state   <= S_ITER;
        end
        S_ITER: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          if (r_iter == c_IW'(ITERATIONS - 1)) begin
            cos_val   <= round_sat(w_x_nxt);
            sin_val   <= round_sat(w_y_nxt);
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_iter <= r_iter + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              r_angle <= $signed(angle);
              r_state <= S_PREROT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_sincos_hs.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cordic_sincos_hs                                           |
// | Purpose  : Self-checking bench for cordic_sincos_hs (8-bit, 8 iters).    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_cordic_sincos_hs;

  localparam int DW   = 8;
  localparam int IT   = 8;
  localparam int LAT  = IT + 2;
  localparam int PI_Q = 101;  // round(pi * 32)
  localparam logic [7:0] DIR_ANGLES [6] = '{8'h00, 8'h32, 8'hEF, 8'h64, 8'h7F, 8'h80};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] angle = 8'h00;
  logic       in_ready, out_valid, range_err;
  logic [7:0] cos_val, sin_val;

  cordic_sincos_hs #(
    .DATA_WIDTH (DW),
    .ITERATIONS (IT),
    .GUARD_BITS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle     (angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_val   (cos_val),
    .sin_val   (sin_val),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int s;
    bit e;
    int t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   iter = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  int   first_acc = -1;
  int   last_pop = -1;
  bit   seen_cur = 1'b0;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = obs - exp;
    checks++;
    if (diff > tol || diff < -tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at step %0d", tag, obs, exp, tol, iter);
    end
  endtask

  function automatic int quant(input real v);
    int r;
    r = $rtoi($floor(v * 128.0 + 0.5));
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  // Ideal result: clamp to +/-pi, then real-valued sin/cos quantised to Q1.7.
  function automatic exp_t model(input logic [7:0] a_in);
    exp_t e;
    int   a;
    real  r;
    a   = int'($signed(a_in));
    e.e = (a > PI_Q) || (a < -PI_Q);
    if (a > PI_Q)       a = PI_Q;
    else if (a < -PI_Q) a = -PI_Q;
    r   = a / 32.0;
    e.c = quant($cos(r));
    e.s = quant($sin(r));
    e.t = 0;
    return e;
  endfunction

  // One clock: drive inputs at the falling edge, then score the transfers of the next rising edge.
  task automatic step(input bit v, input logic [7:0] a, input bit r, input bit rs);
    exp_t e;
    @(negedge clk);
    rst = rs;
    in_valid = v;
    angle = a;
    out_ready = r;
    #1;
    if (rs) begin
      q.delete();
      seen_cur = 1'b0;
    end else begin
      if (q.size() == 0)   check("idle_ready", int'(in_ready), 1, 0);
      else if (!out_valid) check("busy_ready", int'(in_ready), 0, 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0, 0);
        end else begin
          if (!seen_cur) begin
            check("latency", iter - q[0].t, LAT, 0);
            seen_cur = 1'b1;
          end
          if (r) begin
            e = q.pop_front();
            check("cos", int'($signed(cos_val)), e.c, 2);
            check("sin", int'($signed(sin_val)), e.s, 2);
            check("range_err", int'(range_err), int'(e.e), 0);
            seen_cur = 1'b0;
            n_pop++;
            last_pop = iter;
          end
        end
      end
      if (v && in_ready) begin
        e = model(a);
        e.t = iter;
        q.push_back(e);
        n_acc++;
        if (first_acc < 0) first_acc = iter;
      end
    end
    iter++;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0, 0);
      q.delete();
      seen_cur = 1'b0;
    end
  endtask

  initial begin
    int         n, base, base_pop;
    logic [7:0] hc, hs;
    logic       he;

    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_in_ready", int'(in_ready), 0, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_cos", int'(cos_val), 0, 0);
    check("rst_sin", int'(sin_val), 0, 0);
    check("rst_range_err", int'(range_err), 0, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_ready", int'(in_ready), 1, 0);

    foreach (DIR_ANGLES[k]) begin
      base = n_acc;
      step(1'b1, DIR_ANGLES[k], 1'b1, 1'b0);
      check("dir_accept", n_acc - base, 1, 0);
      drain(40);
    end

    // Backpressure: hold the result for 20 cycles, then release with a new angle in the same cycle.
    step(1'b1, 8'h20, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    check("hold_reached", int'(out_valid), 1, 0);
    hc = cos_val;
    hs = sin_val;
    he = range_err;
    repeat (20) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("hold_cos", int'(cos_val), int'(hc), 0);
      check("hold_sin", int'(sin_val), int'(hs), 0);
      check("hold_rerr", int'(range_err), int'(he), 0);
      check("hold_valid", int'(out_valid), 1, 0);
      check("hold_in_ready", int'(in_ready), 0, 0);
    end
    base = n_acc;
    step(1'b1, 8'hC0, 1'b1, 1'b0);
    check("release_in_ready", int'(in_ready), 1, 0);
    check("release_accept", n_acc - base, 1, 0);
    drain(40);

    // Twelve back-to-back angles: no loss, one sample every LAT cycles.
    first_acc = -1;
    base = n_acc;
    base_pop = n_pop;
    n = 0;
    while (n_acc - base < 12 && n < 400) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      n++;
    end
    drain(40);
    check("b2b_pops", n_pop - base_pop, 12, 0);
    check("b2b_span", last_pop - first_acc, 12 * LAT, 0);

    // Reset pulse during ITER cycle 4 discards the sample.
    step(1'b1, 8'h40, 1'b1, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("abort_valid", int'(out_valid), 0, 0);
    check("abort_ready", int'(in_ready), 1, 0);
    repeat (12) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hD8, 1'b1, 1'b0);
    drain(40);

    // Random valid/ready traffic over the full angle range.
    base = n_acc;
    n = 0;
    while (n_acc - base < 40 && n < 3000) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, 1'b0);
      n++;
    end
    check("rand_accepts", n_acc - base, 40, 0);
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
